// File: rtl/mem_responder.sv
// Word-addressed memory responder: one read/write per request, Done pulse LATENCY edges after acceptance.
// Optional byte-lane write enables when MEM_BYTE_LANES_EN is defined (adds ByteEn input).
module mem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 2
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Req,
   input  logic                  Wr,
   input  logic [31:0]           Address,
   input  logic [DATA_WIDTH-1:0] WriteData,
`ifdef MEM_BYTE_LANES_EN
   input  logic [DATA_WIDTH/8-1:0] ByteEn,
`endif
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  Done,
   output logic                  Busy,
   output logic                  AddrErr,
   output logic [1:0]            State_out
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_reg;
   logic [3:0]              count_reg;
   logic                    wr_reg;
   logic [ADDR_WIDTH+1:0]   addr_reg;
   logic [DATA_WIDTH-1:0]   data_reg;
   logic [NB-1:0]           be_reg;
   logic                    done_reg;
   logic                    busy_reg;
   logic                    addr_err_reg;
   logic [DATA_WIDTH-1:0]   read_data_reg;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic [NB-1:0]           be_in;
   logic                    c_wr;
   logic [ADDR_WIDTH+1:0]   c_addr;
   logic [DATA_WIDTH-1:0]   c_data;
   logic [NB-1:0]           c_be;
   logic [ADDR_WIDTH-1:0]   c_idx;
   logic                    misaligned;
   logic                    commit;

   // Address bits above the array are deliberately ignored (addresses wrap).
   logic unused_addr_bits;
   assign unused_addr_bits = ^Address[31:ADDR_WIDTH+2];

`ifdef MEM_BYTE_LANES_EN
   assign be_in = ByteEn;
`else
   assign be_in = '1;
`endif

   // With a single-cycle latency the access commits on the acceptance edge,
   // so it must use the live inputs rather than the latched copies.
   generate
      if (LATENCY == 1) begin : g_direct
         assign c_wr   = Wr;
         assign c_addr = Address[ADDR_WIDTH+1:0];
         assign c_data = WriteData;
         assign c_be   = be_in;
      end else begin : g_latched
         assign c_wr   = wr_reg;
         assign c_addr = addr_reg;
         assign c_data = data_reg;
         assign c_be   = be_reg;
      end
   endgenerate

   assign c_idx      = c_addr[ADDR_WIDTH+1:2];
   assign misaligned = (c_addr[1:0] != 2'b00);
   assign commit     = !Reset &&
                       ((state_reg == WAIT && count_reg == 4'd0) ||
                        (LATENCY == 1 && state_reg == IDLE && Req));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg    <= IDLE;
         count_reg    <= 4'd0;
         wr_reg       <= 1'b0;
         addr_reg     <= '0;
         data_reg     <= '0;
         be_reg       <= '0;
         done_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         addr_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (Req) begin
                  wr_reg    <= Wr;
                  addr_reg  <= Address[ADDR_WIDTH+1:0];
                  data_reg  <= WriteData;
                  be_reg    <= be_in;
                  count_reg <= 4'(LATENCY - 1);
                  busy_reg  <= 1'b1;
                  if (LATENCY == 1) begin
                     state_reg    <= RESP;
                     done_reg     <= 1'b1;
                     addr_err_reg <= misaligned;
                  end else begin
                     state_reg <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (count_reg == 4'd0) begin
                  state_reg    <= RESP;
                  done_reg     <= 1'b1;
                  addr_err_reg <= misaligned;
               end else begin
                  count_reg <= count_reg - 4'd1;
               end
            end
            RESP: begin
               state_reg    <= IDLE;
               done_reg     <= 1'b0;
               addr_err_reg <= 1'b0;
               busy_reg     <= 1'b0;
            end
            default: begin
               state_reg    <= IDLE;
               done_reg     <= 1'b0;
               addr_err_reg <= 1'b0;
               busy_reg     <= 1'b0;
            end
         endcase
      end
   end

   // Storage is never reset so it can map onto block RAM.
   always_ff @(posedge Clk) begin
      if (commit && c_wr && !misaligned) begin
         for (int b = 0; b < NB; b++) begin
            if (c_be[b]) mem[c_idx][b*8 +: 8] <= c_data[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         read_data_reg <= '0;
      end else if (commit && !c_wr && !misaligned) begin
         read_data_reg <= mem[c_idx];
      end
   end

   assign ReadData  = read_data_reg;
   assign Done      = done_reg;
   assign Busy      = busy_reg;
   assign AddrErr   = addr_err_reg;
   assign State_out = state_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table plus hand-written reset/busy/held-request sequences.
module tb_mem_responder;
   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int LAT = 2;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Req;
   logic          Wr;
   logic [31:0]   Address;
   logic [DW-1:0] WriteData;
`ifdef MEM_BYTE_LANES_EN
   logic [DW/8-1:0] ByteEn;
`endif
   logic [DW-1:0] ReadData;
   logic          Done;
   logic          Busy;
   logic          AddrErr;
   logic [1:0]    State_out;

   always #5 Clk = ~Clk;

   mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Req       (Req),
      .Wr        (Wr),
      .Address   (Address),
      .WriteData (WriteData),
`ifdef MEM_BYTE_LANES_EN
      .ByteEn    (ByteEn),
`endif
      .ReadData  (ReadData),
      .Done      (Done),
      .Busy      (Busy),
      .AddrErr   (AddrErr),
      .State_out (State_out)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic pop_compare(input string name);
      exp_t e;
      check({name, " sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({name, " rdata"}, ReadData, e.rd);
         check({name, " addrerr"}, 32'(AddrErr), 32'(e.err));
      end
   endtask

   task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
      Req       = 1'b1;
      Wr        = wr;
      Address   = addr;
      WriteData = wdata;
`ifdef MEM_BYTE_LANES_EN
      ByteEn    = be;
`else
      if (be == 4'h0) Wr = wr;
`endif
   endtask

   task automatic do_access(input vec_t v, input string name);
      int n;
      int busy_n;
      @(negedge Clk);
      drive_req(v.wr, v.addr, v.wdata, v.be);
      sb_q.push_back('{v.exp_rd, v.exp_err});
      @(posedge Clk);
      #1;
      // Scramble inputs after acceptance; they must have no effect.
      Req       = 1'b0;
      Wr        = 1'($urandom);
      Address   = $urandom;
      WriteData = $urandom;
      n = 0;
      busy_n = 0;
      while (n < 40) begin
         @(negedge Clk);
         n++;
         if (Busy) busy_n++;
         if (Done) break;
      end
      check({name, " done"}, 32'(Done), 32'd1);
      check({name, " latency"}, 32'(n), 32'(LAT + 1));
      check({name, " busy_cycles"}, 32'(busy_n), 32'(LAT + 1));
      pop_compare(name);
      $display("[TB] %s wr=%0b addr=%h wdata=%h rdata=%h addrerr=%0b lat=%0d",
               name, v.wr, v.addr, v.wdata, ReadData, AddrErr, n);
      @(negedge Clk);
      check({name, " done_pulse"}, 32'(Done), 32'd0);
      check({name, " idle_busy"}, 32'(Busy), 32'd0);
      check({name, " addrerr_pulse"}, 32'(AddrErr), 32'd0);
   endtask

   vec_t vecs[12];

   initial begin
      int n;
      int dones;
      int first_n;
      int second_n;

      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 4'hF, 32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0013, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 1'b1};
      vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
      vecs[5]  = '{1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 4'hF, 32'hDEAD_BEEF, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 1'b0};
      vecs[7]  = '{1'b0, 32'h0000_0022, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 1'b1};
      vecs[8]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 32'hA5A5_A5A5, 1'b0};
      vecs[9]  = '{1'b0, 32'h0000_07FC, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 32'hCAFE_F00D, 1'b0};
      vecs[11] = '{1'b0, 32'h0000_0030, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 1'b0};

      Reset     = 1'b1;
      Req       = 1'b0;
      Wr        = 1'b0;
      Address   = 32'h0;
      WriteData = '0;
`ifdef MEM_BYTE_LANES_EN
      ByteEn    = '1;
`endif
      repeat (2) @(posedge Clk);
      #1;
      check("reset done", 32'(Done), 32'd0);
      check("reset busy", 32'(Busy), 32'd0);
      check("reset addrerr", 32'(AddrErr), 32'd0);
      check("reset rdata", ReadData, 32'd0);
      check("reset state", 32'(State_out), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         do_access(vecs[i], $sformatf("vec%0d", i));
      end

      // Req pulsed during WAIT with a write must be ignored entirely.
      @(negedge Clk);
      drive_req(1'b0, 32'h10, 32'h0, 4'hF);
      sb_q.push_back('{32'hDEAD_BEEF, 1'b0});
      @(posedge Clk);
      #1;
      drive_req(1'b1, 32'h20, 32'h1, 4'hF);
      @(posedge Clk);
      #1;
      Req = 1'b0;
      dones = 0;
      first_n = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clk);
         if (Done) begin
            dones++;
            if (dones == 1) begin
               first_n = k;
               pop_compare("busy_ignore");
            end
         end
      end
      check("busy_ignore done_count", 32'(dones), 32'd1);
      check("busy_ignore done_pos", 32'(first_n), 32'd2);
      $display("[TB] busy_ignore dones=%0d pos=%0d", dones, first_n);
      do_access('{1'b0, 32'h20, 32'h0, 4'hF, 32'h1111_1111, 1'b0}, "after_ignore_read");

      // Req held high across RESP is re-accepted in the following IDLE cycle.
      @(negedge Clk);
      drive_req(1'b0, 32'h10, 32'h0, 4'hF);
      sb_q.push_back('{32'hDEAD_BEEF, 1'b0});
      sb_q.push_back('{32'hDEAD_BEEF, 1'b0});
      @(posedge Clk);
      dones = 0;
      first_n = 0;
      second_n = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge Clk);
         if (Done) begin
            dones++;
            pop_compare("held_req");
            if (dones == 1) first_n = k;
            if (dones == 2) begin
               second_n = k;
               Req = 1'b0;
            end
         end
      end
      Req = 1'b0;
      check("held_req done_count", 32'(dones), 32'd2);
      check("held_req first_pos", 32'(first_n), 32'(LAT + 1));
      check("held_req second_pos", 32'(second_n), 32'(2 * LAT + 3));
      $display("[TB] held_req dones=%0d pos=%0d,%0d", dones, first_n, second_n);

      // Reset during WAIT aborts a write: no Done, Busy drops at once.
      @(negedge Clk);
      drive_req(1'b1, 32'h30, 32'h55, 4'hF);
      @(posedge Clk);
      #1;
      Req = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      check("rst_wait busy", 32'(Busy), 32'd0);
      check("rst_wait done", 32'(Done), 32'd0);
      check("rst_wait state", 32'(State_out), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      dones = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         if (Done) dones++;
      end
      check("rst_wait no_done", 32'(dones), 32'd0);
      $display("[TB] rst_wait dones=%0d", dones);
      do_access('{1'b0, 32'h30, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0}, "after_rst_read");

      // Reset during RESP cancels the Done pulse.
      @(negedge Clk);
      drive_req(1'b0, 32'h10, 32'h0, 4'hF);
      @(posedge Clk);
      #1;
      Req = 1'b0;
      n = 0;
      while (n < 40) begin
         @(negedge Clk);
         n++;
         if (Done) break;
      end
      check("rst_resp done_seen", 32'(Done), 32'd1);
      check("rst_resp rdata", ReadData, 32'hDEAD_BEEF);
      Reset = 1'b1;
      #1;
      check("rst_resp done_cancel", 32'(Done), 32'd0);
      check("rst_resp busy", 32'(Busy), 32'd0);
      $display("[TB] rst_resp lat=%0d done_after_reset=%0b", n, Done);
      @(negedge Clk);
      Reset = 1'b0;

`ifdef MEM_BYTE_LANES_EN
      do_access('{1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0}, "be_full");
      do_access('{1'b1, 32'h40, 32'h0000_0000, 4'h5, 32'h0, 1'b0}, "be_0101");
      do_access('{1'b1, 32'h40, 32'h1234_5678, 4'h0, 32'h0, 1'b0}, "be_none");
      do_access('{1'b0, 32'h40, 32'h0, 4'h0, 32'hFF00_FF00, 1'b0}, "be_read");
`endif

      check("scoreboard empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
